instruction_fetch_unit: RTL and testbench

//  Read-side initiator for instruction_ram: owns the program counter, issues

---
 rtl/instruction_fetch_unit.sv | 90 +++++++++
 tb/tb_instruction_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one-cycle reads to instruction_ram and
// hands each captured word to the control unit over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int                           ADDRESS_BUS_WIDTH = 10,
    parameter int                           INSTRUCTION_WIDTH = 19,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_ADDRESS     = 10'h200,
    parameter int                           PC_STEP           = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_enable,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    output logic                         mem_read,
    output logic                         mem_write,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_addr
);
    localparam int AW = ADDRESS_BUS_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, VALID} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_seq;
    logic [AW-1:0] redirect_tgt;

    assign mem_write    = 1'b0;
    assign pc_seq       = pc + AW'(PC_STEP);            // wraps modulo 2^AW
    assign redirect_tgt = redirect_addr & ~AW'(3);      // word-align the target

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_ADDRESS;
            mem_address <= RESET_ADDRESS;
            mem_read    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            mem_read <= 1'b0;
            if (state != IDLE && redirect_valid) begin
                // A stale read in flight is dropped simply by never entering
                // CAPTURE for it: the new FETCH overwrites the request.
                pc          <= redirect_tgt;
                mem_address <= redirect_tgt;
                mem_read    <= 1'b1;
                instr_valid <= 1'b0;
                state       <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        if (redirect_valid) begin
                            pc <= redirect_tgt;
                        end else if (fetch_enable) begin
                            mem_address <= pc;
                            mem_read    <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                    FETCH: state <= CAPTURE;
                    CAPTURE: begin
                        instr       <= mem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                    VALID: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            pc          <= pc_seq;
                            if (fetch_enable) begin
                                mem_address <= pc_seq;
                                mem_read    <= 1'b1;
                                state       <= FETCH;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered-read RAM model.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic [9:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [18:0] mem_data = '0;
    logic [18:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [9:0]  redirect_addr;

    logic [18:0] mem [0:255];
    int nvec = 0;
    int nerr = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_read) mem_data <= mem[mem_address[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Three cycles from the edge that enters FETCH to the word being presented.
    task automatic expect_fetch(input logic [9:0] a, input logic [18:0] w);
        tick;
        redirect_valid = 1'b0;
        chk("rd_issue", 32'(mem_read), 32'd1);
        chk("rd_addr", 32'(mem_address), 32'(a));
        chk("vld_drop", 32'(instr_valid), 32'd0);
        tick;
        chk("rd_pulse", 32'(mem_read), 32'd0);
        chk("vld_cap", 32'(instr_valid), 32'd0);
        tick;
        chk("vld", 32'(instr_valid), 32'd1);
        chk("instr", 32'(instr), 32'(w));
        chk("instr_pc", 32'(instr_pc), 32'(a));
        chk("wr", 32'(mem_write), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 19'h40000 | 19'(i);
        mem[8'h80] = 19'h20110;
        mem[8'h81] = 19'h20220;
        mem[8'h82] = 19'h07600;
        mem[8'h83] = 19'h24330;
        reset_n = 1'b0; fetch_enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        tick; tick;
        chk("rst_addr", 32'(mem_address), 32'h200);
        chk("rst_rd", 32'(mem_read), 32'd0);
        chk("rst_wr", 32'(mem_write), 32'd0);
        chk("rst_vld", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);

        reset_n = 1'b1; fetch_enable = 1'b1;
        expect_fetch(10'h200, 19'h20110);

        // stall five cycles in VALID
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_vld", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'h20110);
            chk("stall_rd", 32'(mem_read), 32'd0);
        end
        instr_ready = 1'b1;
        expect_fetch(10'h204, 19'h20220);
        expect_fetch(10'h208, 19'h07600);
        expect_fetch(10'h20C, 19'h24330);

        // redirect while the 0x210 read is in CAPTURE
        tick;
        chk("seq_addr", 32'(mem_address), 32'h210);
        tick;
        chk("cap_rd", 32'(mem_read), 32'd0);
        redirect_valid = 1'b1; redirect_addr = 10'h1F7;
        expect_fetch(10'h1F4, 19'h4007D);

        // redirect coincident with handshake: no pc+4
        redirect_valid = 1'b1; redirect_addr = 10'h213;
        expect_fetch(10'h210, 19'h40084);

        // top of memory, then wrap to zero
        redirect_valid = 1'b1; redirect_addr = 10'h3FC;
        expect_fetch(10'h3FC, 19'h400FF);
        expect_fetch(10'h000, 19'h40000);

        // fetch_enable dropped mid-fetch: finish, deliver, then park
        tick;
        chk("fe_addr", 32'(mem_address), 32'h004);
        fetch_enable = 1'b0;
        tick;
        tick;
        chk("fe_vld", 32'(instr_valid), 32'd1);
        chk("fe_instr", 32'(instr), 32'h40001);
        tick;
        chk("fe_hs_vld", 32'(instr_valid), 32'd0);
        chk("fe_idle_rd", 32'(mem_read), 32'd0);
        tick;
        chk("fe_idle_rd2", 32'(mem_read), 32'd0);
        fetch_enable = 1'b1; instr_ready = 1'b0;
        tick;
        chk("resume_rd", 32'(mem_read), 32'd1);
        chk("resume_addr", 32'(mem_address), 32'h008);
        tick;

        // async reset in CAPTURE, no clock edge
        reset_n = 1'b0;
        #2;
        chk("arst_vld", 32'(instr_valid), 32'd0);
        chk("arst_rd", 32'(mem_read), 32'd0);
        chk("arst_addr", 32'(mem_address), 32'h200);
        reset_n = 1'b1;
        expect_fetch(10'h200, 19'h20110);

        // async reset in VALID drops the instruction immediately
        reset_n = 1'b0;
        #1;
        chk("arst_v_vld", 32'(instr_valid), 32'd0);
        chk("arst_v_instr", 32'(instr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
